// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
//   Memory-side responder for the core's data-memory port. It handles one
//   request at a time over a valid/ready channel, inserts LATENCY wait states,
//   accesses a word-organised array, and returns load data plus an error flag
//   over a valid/ready response channel.
//
//   Optional feature macro: DMEM_PERF_COUNTERS_EN
//     When defined, the ports perf_rd_cnt, perf_wr_cnt and perf_stall_cnt are
//     added along with their counters. When undefined, neither the ports nor
//     the counter logic exist. Request/response behaviour is identical in
//     both builds.
// ----------------------------------------------------------------------------
module dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
`ifdef DMEM_PERF_COUNTERS_EN
  ,
  output logic [31:0] perf_rd_cnt,
  output logic [31:0] perf_wr_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  // Number of word-index bits into the array.
  localparam int unsigned IDX_W = $clog2(DEPTH);

  // Wait counter start value; only meaningful when LATENCY > 0.
  localparam logic [3:0] WAIT_INIT = (LATENCY > 32'd0) ? 4'(LATENCY - 32'd1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // An access is illegal when misaligned or when any address bit above the
  // array's byte range is set.
  function automatic logic addr_err(input logic [31:0] addr);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr[1:0] != 2'b00);
    out_of_range = ((addr >> (IDX_W + 32'd2)) != 32'd0);
    return misaligned || out_of_range;
  endfunction

  // Merge the enabled bytes of new_word into old_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] result;
    result = old_word;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) begin
        result[8*b +: 8] = new_word[8*b +: 8];
      end else begin
        result[8*b +: 8] = old_word[8*b +: 8];
      end
    end
    return result;
  endfunction

  // --------------------------------------------------------------------------
  // State and storage
  // --------------------------------------------------------------------------
  state_t       state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         we_q, we_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [3:0]   be_q, be_d;
  logic         req_ready_q, req_ready_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [31:0]  rsp_rdata_q, rsp_rdata_d;
  logic         rsp_err_q, rsp_err_d;

  logic [31:0]  mem_q [DEPTH];

  // Access operands: in IDLE the live request (zero-latency access happens at
  // the accept edge), otherwise the captured request.
  logic             accept_s;
  logic             access_s;
  logic             acc_we_s;
  logic [31:0]      acc_addr_s;
  logic [31:0]      acc_wdata_s;
  logic [3:0]       acc_be_s;
  logic             acc_err_s;
  logic [IDX_W-1:0] acc_idx_s;
  logic             mem_we_s;

  assign accept_s    = (state_q == ST_IDLE) && req_valid && req_ready_q;
  assign acc_we_s    = (state_q == ST_IDLE) ? req_we    : we_q;
  assign acc_addr_s  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign acc_wdata_s = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign acc_be_s    = (state_q == ST_IDLE) ? req_be    : be_q;
  assign acc_err_s   = addr_err(acc_addr_s);
  assign acc_idx_s   = acc_addr_s[IDX_W+1:2];

  // FSM next state, request capture and wait-state counting.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    access_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (LATENCY == 32'd0) begin
            access_s = 1'b1;
            state_d  = ST_RESP;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = ST_WAIT;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d   = cnt_q - 4'd1;
          state_d = ST_WAIT;
        end else begin
          access_s = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Access result: response data/error update and array write enable. The
  // response registers only change at an access so they hold after handshake.
  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_s    = 1'b0;
    if (access_s) begin
      if (acc_err_s) begin
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b1;
      end else if (acc_we_s) begin
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
        mem_we_s    = 1'b1;
      end else begin
        rsp_rdata_d = mem_q[acc_idx_s];
        rsp_err_d   = 1'b0;
      end
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Handshake outputs are registered from the next state.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
  end

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      be_q        <= 4'd0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array write; contents survive reset, and nothing is written while reset
  // is asserted so a store abandoned in WAIT never lands.
  always_ff @(posedge clk) begin
    if (mem_we_s && reset) begin
      mem_q[acc_idx_s] <= merge_bytes(mem_q[acc_idx_s], acc_wdata_s, acc_be_s);
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef DMEM_PERF_COUNTERS_EN
  logic [31:0] perf_rd_cnt_q, perf_rd_cnt_d;
  logic [31:0] perf_wr_cnt_q, perf_wr_cnt_d;
  logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;

  // Count accepted loads/stores (errors included) and back-pressured cycles.
  always_comb begin
    perf_rd_cnt_d    = perf_rd_cnt_q;
    perf_wr_cnt_d    = perf_wr_cnt_q;
    perf_stall_cnt_d = perf_stall_cnt_q;
    if (accept_s) begin
      if (req_we) begin
        perf_wr_cnt_d = perf_wr_cnt_q + 32'd1;
      end else begin
        perf_rd_cnt_d = perf_rd_cnt_q + 32'd1;
      end
    end else begin
      perf_rd_cnt_d = perf_rd_cnt_q;
    end
    if (rsp_valid_q && !rsp_ready) begin
      perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
    end else begin
      perf_stall_cnt_d = perf_stall_cnt_q;
    end
  end

  // Performance counter registers, cleared by reset and wrapping at 2^32.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_rd_cnt_q    <= 32'd0;
      perf_wr_cnt_q    <= 32'd0;
      perf_stall_cnt_q <= 32'd0;
    end else begin
      perf_rd_cnt_q    <= perf_rd_cnt_d;
      perf_wr_cnt_q    <= perf_wr_cnt_d;
      perf_stall_cnt_q <= perf_stall_cnt_d;
    end
  end

  assign perf_rd_cnt    = perf_rd_cnt_q;
  assign perf_wr_cnt    = perf_wr_cnt_q;
  assign perf_stall_cnt = perf_stall_cnt_q;
`endif

endmodule
